// File: rtl/arbitro_vc_d.sv
// VC0/VC1 -> D0/D1 arbiter: combinational pop, registered push one cycle later, idle report.
// Optional ROUND_ROBIN_EN macro replaces strict VC0 priority with a 1-bit alternating pointer.
module arbitro_vc_d #(
    parameter int BITNUMBER = 6,
    parameter int DEST_BIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 VC0_empty,
    input  logic                 VC1_empty,
    input  logic [BITNUMBER-1:0] VC0_data,
    input  logic [BITNUMBER-1:0] VC1_data,
    input  logic                 D0_pause,
    input  logic                 D1_pause,
    output logic                 VC0_pop,
    output logic                 VC1_pop,
    output logic                 D0_push,
    output logic                 D1_push,
    output logic [BITNUMBER-1:0] data_out,
    output logic                 idle
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t               state;
    logic                 elig0, elig1;
    logic                 grant0, grant1;
    logic                 pop_any;
    logic [BITNUMBER-1:0] pop_word;

    // A head is only eligible when the destination it targets has room.
    assign elig0 = !VC0_empty && !(VC0_data[DEST_BIT] ? D1_pause : D0_pause);
    assign elig1 = !VC1_empty && !(VC1_data[DEST_BIT] ? D1_pause : D0_pause);

`ifdef ROUND_ROBIN_EN
    logic ptr;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!ptr) begin
            grant0 = elig0;
            grant1 = !elig0 && elig1;
        end else begin
            grant1 = elig1;
            grant0 = !elig1 && elig0;
        end
    end

    // Pointer only moves when the preferred VC actually wins.
    always_ff @(posedge clk) begin
        if (!reset)
            ptr <= 1'b0;
        else if (ptr ? VC1_pop : VC0_pop)
            ptr <= ~ptr;
    end
`else
    assign grant0 = elig0;
    assign grant1 = !elig0 && elig1;
`endif

    assign VC0_pop  = reset && grant0;
    assign VC1_pop  = reset && grant1;
    assign pop_any  = VC0_pop || VC1_pop;
    assign pop_word = VC0_pop ? VC0_data : VC1_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idle     <= 1'b1;
            D0_push  <= 1'b0;
            D1_push  <= 1'b0;
            data_out <= '0;
        end else begin
            D0_push <= pop_any && !pop_word[DEST_BIT];
            D1_push <= pop_any && pop_word[DEST_BIT];
            if (pop_any)
                data_out <= pop_word;
            case (state)
                IDLE: begin
                    if (pop_any) begin
                        state <= ACTIVE;
                        idle  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // No pop now means nothing pushes next cycle either.
                    if (!pop_any && VC0_empty && VC1_empty) begin
                        state <= IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_arbitro_vc_d.sv
// Randomized and directed bench for arbitro_vc_d against a cycle-level reference model.
module tb_arbitro_vc_d;
    localparam int BN = 6;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          VC0_empty, VC1_empty;
    logic [BN-1:0] VC0_data, VC1_data;
    logic          D0_pause, D1_pause;
    logic          VC0_pop, VC1_pop, D0_push, D1_push, idle;
    logic [BN-1:0] data_out;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic          m_d0, m_d1, m_idle, m_active, m_rr;
    logic [BN-1:0] m_data;

    arbitro_vc_d #(.BITNUMBER(BN), .DEST_BIT(DB)) dut (
        .clk(clk), .reset(reset),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data(VC0_data), .VC1_data(VC1_data),
        .D0_pause(D0_pause), .D1_pause(D1_pause),
        .VC0_pop(VC0_pop), .VC1_pop(VC1_pop),
        .D0_push(D0_push), .D1_push(D1_push),
        .data_out(data_out), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check pops, advance, check registered outputs.
    task automatic cyc(input logic rst, input logic e0, input logic e1,
                       input logic [BN-1:0] w0, input logic [BN-1:0] w1,
                       input logic p0, input logic p1);
        logic [BN-1:0] w[2];
        logic          el[2];
        logic          g[2];
        int            pref;
        reset = rst; VC0_empty = e0; VC1_empty = e1;
        VC0_data = w0; VC1_data = w1; D0_pause = p0; D1_pause = p1;
        w[0] = w0; w[1] = w1;
        el[0] = !e0 && !(w0[DB] ? p1 : p0);
        el[1] = !e1 && !(w1[DB] ? p1 : p0);
        g[0] = 1'b0; g[1] = 1'b0;
        if (rst) begin
`ifdef ROUND_ROBIN_EN
            pref = int'(m_rr);
`else
            pref = 0;
`endif
            if (el[pref]) begin
                g[pref] = 1'b1;
                m_rr = ~m_rr;
            end else if (el[1-pref]) begin
                g[1-pref] = 1'b1;
            end
        end
        #1;
        chk("vc0_pop", VC0_pop, g[0]);
        chk("vc1_pop", VC1_pop, g[1]);
        if (!rst) begin
            m_d0 = 0; m_d1 = 0; m_data = '0; m_active = 0; m_rr = 0;
        end else if (g[0] || g[1]) begin
            m_data = g[0] ? w[0] : w[1];
            m_d0 = !m_data[DB]; m_d1 = m_data[DB];
            m_active = 1;
        end else begin
            m_d0 = 0; m_d1 = 0;
            if (e0 && e1) m_active = 0;
        end
        m_idle = !m_active;
        @(posedge clk); #1;
        chk("d0_push", D0_push, m_d0);
        chk("d1_push", D1_push, m_d1);
        chk("data_out", data_out, m_data);
        chk("idle", idle, m_idle);
    endtask

    initial begin
        logic [BN-1:0] a, b;
        m_rr = 0; m_active = 0;
        reset = 0; VC0_empty = 1; VC1_empty = 1; VC0_data = '0; VC1_data = '0;
        D0_pause = 0; D1_pause = 0;
        @(posedge clk); #1;

        // reset held with traffic present
        repeat (3) cyc(0, 0, 0, 6'b000001, 6'b100011, 0, 0);
        // routing
        cyc(1, 0, 1, 6'b000001, 6'b0, 0, 0);
        cyc(1, 0, 1, 6'b010000, 6'b0, 0, 0);
        cyc(1, 1, 1, 6'b0, 6'b0, 0, 0);
        cyc(1, 1, 1, 6'b0, 6'b0, 0, 0);
        // priority / alternation
        repeat (4) cyc(1, 0, 0, 6'b000010, 6'b100011, 0, 0);
        // head-of-line bypass
        cyc(1, 0, 0, 6'b010010, 6'b100100, 0, 1);
        cyc(1, 0, 1, 6'b010010, 6'b0, 0, 1);
        cyc(1, 0, 1, 6'b010010, 6'b0, 0, 0);
        cyc(1, 1, 1, 6'b0, 6'b0, 1, 1);
        // both paused with traffic: stays busy
        cyc(1, 0, 0, 6'b000111, 6'b110000, 1, 1);
        cyc(1, 0, 0, 6'b000111, 6'b110000, 1, 1);
        // drain: 32 alternating words then empty
        for (int i = 0; i < 32; i++) begin
            a = BN'($urandom);
            a[DB] = i[0];
            if (i % 2 == 0) cyc(1, 0, 1, a, 6'b0, 0, 0);
            else            cyc(1, 1, 0, 6'b0, a, 0, 0);
        end
        repeat (3) cyc(1, 1, 1, 6'b0, 6'b0, 0, 0);
        // mid-operation reset while a pop would occur
        cyc(1, 0, 0, 6'b000101, 6'b010101, 0, 0);
        cyc(0, 0, 0, 6'b001001, 6'b011001, 0, 0);
        cyc(1, 1, 1, 6'b0, 6'b0, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = BN'($urandom);
            b = BN'($urandom);
            cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), a, b,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arbitro_vc_d.md
# arbitro_vc_d

VC-to-destination arbiter between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1). Each cycle it picks at most one non-empty VC whose head word can be accepted by its destination, pops it and pushes it one cycle later into D0 or D1 according to the word's destination bit. It also reports link idleness to the top-level control FSM.

## Interface
- BITNUMBER, 6: word width.
- DEST_BIT, 4: bit index selecting the destination (0 → D0, 1 → D1).

- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- VC0_empty  in  1  VC0 FIFO empty.
- VC1_empty  in  1  VC1 FIFO empty.
- VC0_data  in  BITNUMBER  VC0 head word (first-word-fall-through, valid while !VC0_empty).
- VC1_data  in  BITNUMBER  VC1 head word (same rule).
- D0_pause  in  1  D0 at/above its almost-full threshold (Umbral_D).
- D1_pause  in  1  D1 at/above its almost-full threshold.
- VC0_pop  out  1  combinational pop to VC0.
- VC1_pop  out  1  combinational pop to VC1.
- D0_push  out  1  registered push to D0.
- D1_push  out  1  registered push to D1.
- data_out  out  BITNUMBER  registered word for D0/D1.
- idle  out  1  registered; high when no word pending or in flight.

## Operation
- Eligibility: VCn eligible iff !VCn_empty and the pause of D[VCn_data[DEST_BIT]] is low.
- Grant (default build): strict priority, VC0 over VC1. At most one pop per cycle; never both.
- Pop asserted in cycle N ⇒ at edge N+1: data_out ← popped word, D0_push = (word[DEST_BIT]==0), D1_push = (word[DEST_BIT]==1). No pop in N ⇒ both pushes 0 in N+1, data_out holds.
- Word forwarded unmodified (bit 5 VC tag preserved).
- Blocked head (destination paused) does not block the other VC: VC1 may be granted while VC0 head waits on a paused D.
- State machine (2 states, encoded one-hot or binary):
  - IDLE: idle=1. Go ACTIVE when any pop occurs.
  - ACTIVE: idle=0. Go IDLE when no pop this cycle, both VCs empty, and no push pending next cycle.
- Reset (reset==0 at edge): pops forced 0 during reset; D0_push=0, D1_push=0, data_out=0, idle=1, state=IDLE, round-robin pointer=VC0. In-flight word is discarded.

## Timing
- Pop→push latency: exactly 1 cycle; throughput 1 word/cycle.
- Pause is sampled combinationally in the pop cycle; the in-flight word still pushes even if pause rises in N+1 (Umbral_D ≥ 1 gives the required one-word margin).
- Both VCs empty: no pop; after last push drains, idle rises on the following edge.
- Both destinations paused: no pop, outputs hold, state stays ACTIVE until the idle condition holds.
- Reset released at edge R: first pop possible in cycle R (combinational), first push at R+1.

## Configuration
- ROUND_ROBIN_EN defined: grant alternates; a 1-bit pointer names the preferred VC, flips to the other VC after each grant to the preferred one; if the preferred VC is ineligible the other is granted and the pointer is unchanged.
- Undefined: strict VC0 priority as above; pointer logic absent.

## Test plan
- Reset: hold reset=0 three cycles with both VCs non-empty → no pops, pushes 0, data_out=0, idle=1.
- Routing: VC0 head 'b000001, VC1 empty, no pause → VC0_pop cycle N; D0_push=1, data_out='b000001 at N+1. Then VC0 head 'b010000 → D1_push with 'b010000.
- Priority: both VCs non-empty with heads 'b000010 / 'b100011 for 4 cycles → default build pops VC0 all four; ROUND_ROBIN_EN build pops VC0,VC1,VC0,VC1.
- Head-of-line bypass: D1_pause=1, VC0 head 'b010010, VC1 head 'b100100 → VC1 popped, D0_push with 'b100100; VC0 stays until D1_pause drops, then D1_push 'b010010 next cycle.
- Drain/idle: push 32 alternating words then empty both VCs → idle=0 during traffic, idle=1 one cycle after final push.
- Mid-operation reset: assert reset=0 in a pop cycle → next edge D0_push=D1_push=0, data_out=0, idle=1; popped word not delivered.
